// File: rtl/range_uart_pkg.sv
// Shared FSM state type, report byte constants and byte/parity helpers for range_uart_reporter.
package range_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic [7:0] STATUS_OK     = 8'hA5;
    localparam logic [7:0] STATUS_ERR    = 8'hEE;
    localparam logic [7:0] ERR_PAYLOAD   = 8'h00;
    localparam int         BITS_PER_BYTE = 8;

    function automatic logic [7:0] status_byte(input logic err);
        return err ? STATUS_ERR : STATUS_OK;
    endfunction

    // An errored measurement carries no meaningful range, so its payload is forced to a constant.
    function automatic logic [7:0] payload_byte(input logic err, input logic [7:0] rng);
        return err ? ERR_PAYLOAD : rng;
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: bit_done pulses on the last cycle of every CLKS_PER_BIT-cycle bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Hold at zero while restarting so the first bit after restart gets its full period.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = !restart && (cnt_q == LAST);

endmodule

// File: rtl/range_uart_reporter.sv
// Latches a range result on valid/ready and sends a 2-byte status+payload report over UART (8N1, LSB first).
// Define RANGE_UART_PARITY_EN to insert an even-parity bit after each data byte.
module range_uart_reporter
    import range_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] range_in,
    input  logic       error_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    state_e      state_q;
    logic        tx_q;
    logic        ready_q;
    logic        overrun_q;
    logic [7:0]  range_q;
    logic        error_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        byte_idx_q;
`ifdef RANGE_UART_PARITY_EN
    logic        parity_q;
`endif

    logic        timer_restart_s;
    logic        bit_done_s;

    assign timer_restart_s = (state_q == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (timer_restart_s),
        .bit_done (bit_done_s)
    );

    // Report FSM; tx, ready and overrun are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
            range_q    <= 8'h00;
            error_q    <= 1'b0;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 1'b0;
`ifdef RANGE_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            if (valid_in && !ready_q) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (valid_in && ready_q) begin
                        range_q    <= range_in;
                        error_q    <= error_in;
                        shift_q    <= status_byte(error_in);
`ifdef RANGE_UART_PARITY_EN
                        parity_q   <= even_parity(status_byte(error_in));
`endif
                        byte_idx_q <= 1'b0;
                        bit_idx_q  <= 3'd0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= START;
                    end
                end

                START: begin
                    if (bit_done_s) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= 3'd0;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    if (bit_done_s) begin
                        if (bit_idx_q == 3'(BITS_PER_BYTE - 1)) begin
`ifdef RANGE_UART_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

`ifdef RANGE_UART_PARITY_EN
                PARITY: begin
                    if (bit_done_s) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (bit_done_s) begin
                        if (!byte_idx_q) begin
                            // Payload start bit follows the status stop bit with no idle gap.
                            shift_q    <= payload_byte(error_q, range_q);
`ifdef RANGE_UART_PARITY_EN
                            parity_q   <= even_parity(payload_byte(error_q, range_q));
`endif
                            byte_idx_q <= 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_out = ready_q;
    assign busy      = ~ready_q;
    assign tx        = tx_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_range_uart_reporter.sv
// Randomised self-checking bench for range_uart_reporter: a UART monitor decodes tx and a report-level model predicts bytes, timing and overrun.
module tb_range_uart_reporter;

    localparam int CPB = 4;
`ifdef RANGE_UART_PARITY_EN
    localparam int BITS_PER_FRAME_BYTE = 11;
`else
    localparam int BITS_PER_FRAME_BYTE = 10;
`endif
    localparam int FRAME_CYCLES = 2 * BITS_PER_FRAME_BYTE * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] range_in;
    logic       error_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx;
    logic       busy;
    logic       overrun;

    int n_checks;
    int n_errors;
    logic exp_overrun;

    logic [7:0] mon_bytes[$];
    logic       mon_par[$];
    logic       mon_stop[$];

    range_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .range_in  (range_in),
        .error_in  (error_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx        (tx),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART receiver: samples each bit near its middle; frames touched by reset are discarded.
    initial begin : uart_monitor
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ok   = 1'b1;
                data = 8'h00;
                par  = 1'b0;
                @(negedge clk);
                if (tx !== 1'b0 || rst_n !== 1'b1) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    data[i] = tx;
                    if (rst_n !== 1'b1) ok = 1'b0;
                end
`ifdef RANGE_UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = tx;
                if (rst_n !== 1'b1) ok = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                stop = tx;
                if (rst_n !== 1'b1) ok = 1'b0;
                if (ok) begin
                    mon_bytes.push_back(data);
                    mon_par.push_back(par);
                    mon_stop.push_back(stop);
                end
            end
        end
    end

    // Compare the two decoded bytes against what the report rules say should have been sent.
    task automatic check_frame(input logic [7:0] r, input logic e);
        logic [7:0] exp_b[2];
        exp_b[0] = e ? 8'hEE : 8'hA5;
        exp_b[1] = e ? 8'h00 : r;
        check_val("byte_count", 32'(mon_bytes.size()), 32'd2);
        for (int k = 0; k < 2; k++) begin
            if (mon_bytes.size() > 0) begin
                check_val(k == 0 ? "status_byte" : "payload_byte", 32'(mon_bytes.pop_front()), 32'(exp_b[k]));
                check_val("stop_bit", 32'(mon_stop.pop_front()), 32'd1);
`ifdef RANGE_UART_PARITY_EN
                check_val("parity_bit", 32'(mon_par.pop_front()), 32'(^exp_b[k]));
`else
                void'(mon_par.pop_front());
`endif
            end
        end
    endtask

    // One report: optional intruding valid pulse at cycle intrude_at, optional reset at cycle abort_at.
    task automatic run_report(input logic [7:0] r, input logic e, input int intrude_at, input int abort_at);
        int lat;
        int wait_cnt;
        wait_cnt = 0;
        while (ready_out !== 1'b1 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_val("ready_before_send", 32'(ready_out), 32'd1);
        range_in = r;
        error_in = e;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        range_in = 8'($urandom);
        error_in = 1'($urandom);
        lat = 1;
        check_val("ready_drop", 32'(ready_out), 32'd0);
        check_val("start_bit_tx", 32'(tx), 32'd0);
        check_val("busy_high", 32'(busy), 32'd1);
        while (ready_out !== 1'b1 && lat < 400) begin
            if (lat == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_val("abort_tx", 32'(tx), 32'd1);
                check_val("abort_ready", 32'(ready_out), 32'd1);
                check_val("abort_overrun", 32'(overrun), 32'd0);
                exp_overrun = 1'b0;
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
                repeat (60) @(negedge clk);
                check_val("abort_no_partial_byte", 32'(mon_bytes.size()), 32'd0);
                return;
            end
            if (lat == intrude_at) begin
                valid_in = 1'b1;
                range_in = ~r;
                error_in = ~e;
                exp_overrun = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            if (intrude_at > 0 && lat == intrude_at + 1) begin
                check_val("overrun_set", 32'(overrun), 32'd1);
            end
            @(negedge clk);
            lat++;
        end
        valid_in = 1'b0;
        check_val("ready_latency", 32'(lat), 32'(FRAME_CYCLES + 1));
        check_val("overrun_state", 32'(overrun), 32'(exp_overrun));
        check_frame(r, e);
    endtask

    initial begin : stimulus
        int low_cnt;
        logic [7:0] r;
        logic       e;
        n_checks    = 0;
        n_errors    = 0;
        exp_overrun = 1'b0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        range_in = 8'h00;
        error_in = 1'b0;

        // Reset held, then idle line after release.
        repeat (3) @(negedge clk);
        check_val("rst_tx", 32'(tx), 32'd1);
        check_val("rst_ready", 32'(ready_out), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check_val("idle_tx_low_cycles", 32'(low_cnt), 32'd0);
        check_val("idle_no_bytes", 32'(mon_bytes.size()), 32'd0);

        // Directed reports.
        run_report(8'h3C, 1'b0, 0, 0);
        run_report(8'h7F, 1'b1, 0, 0);
        run_report(8'h07, 1'b0, 0, 0);
        run_report(8'h96, 1'b0, 10, 0);
        repeat (30) @(negedge clk);
        check_val("no_third_byte", 32'(mon_bytes.size()), 32'd0);
        run_report(8'h5A, 1'b0, 0, 30);
        run_report(8'hC3, 1'b0, 0, 0);

        // Randomised reports, including back-to-back (gap 0) and intruding pulses.
        for (int n = 0; n < 14; n++) begin
            r = 8'($urandom);
            e = ($urandom_range(0, 3) == 0);
            run_report(r, e, ($urandom_range(0, 3) == 0) ? $urandom_range(2, FRAME_CYCLES - 6) : 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
